// File: rtl/fifo_bank_pkg.sv
// Shared constants for the multi-terminal FIFO bank: the overflow policy
// encodings and the width of the per-terminal overflow event counter.
package fifo_bank_pkg;

  // A push to a full FIFO discards the incoming packet.
  localparam int OVF_DROP      = 0;
  // A push to a full FIFO evicts the oldest packet to make room.
  localparam int OVF_OVERWRITE = 1;

  // Overflow event counter width; the counter saturates at its all-ones value.
  localparam int OVF_CNT_W = 8;
  localparam logic [OVF_CNT_W-1:0] OVF_CNT_MAX = '1;

endpackage

// File: rtl/term_fifo.sv
// Single-terminal circular FIFO with first-word-fall-through output,
// per-terminal flush and a saturating overflow event counter.
module term_fifo
  import fifo_bank_pkg::*;
#(
  parameter int PCKG_SZ   = 40,
  parameter int DEEP_FIFO = 8,
  parameter int OVF_MODE  = OVF_DROP,
  localparam int AW       = $clog2(DEEP_FIFO),
  localparam int CW       = AW + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [PCKG_SZ-1:0]   data_in,
  input  logic                 pop,
  input  logic                 flush,
  output logic [PCKG_SZ-1:0]   data_out,
  output logic                 pndng,
  output logic                 full,
  output logic [CW-1:0]        count,
  output logic [OVF_CNT_W-1:0] ovf_cnt
);

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEEP_FIFO);
  localparam logic          OVERWRITE = (OVF_MODE == OVF_OVERWRITE);

  // Saturating increment for the overflow event counter.
  function automatic logic [OVF_CNT_W-1:0] ovf_sat_inc(input logic [OVF_CNT_W-1:0] v);
    return (v == OVF_CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic [PCKG_SZ-1:0]   mem_q [DEEP_FIFO];
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [OVF_CNT_W-1:0] ovf_q, ovf_d;

  logic is_empty;
  logic is_full;
  logic pop_ok;
  logic ovf_evt;
  logic wr_en;
  logic rd_adv;

  // Status is decoded from the registered occupancy only, so pndng/full
  // never depend combinationally on push or pop.
  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == DEPTH_C);

  // A pop on an empty FIFO is ignored; a push+pop on a full FIFO is a
  // plain pass-through and therefore not an overflow event.
  assign pop_ok  = pop && !is_empty;
  assign ovf_evt = push && is_full && !pop;

  // In overwrite mode the write slot of a full FIFO is the head slot, so
  // writing it and advancing the read pointer evicts exactly the oldest packet.
  assign wr_en  = !flush && push && (!is_full || pop_ok || OVERWRITE);
  assign rd_adv = !flush && (pop_ok || (ovf_evt && OVERWRITE));

  // Next-state computation: flush wins over push and pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = '0;
    end else begin
      // Power-of-two depth lets the pointers wrap by natural overflow.
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_adv) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (wr_en && !rd_adv) begin
        cnt_d = cnt_q + 1'b1;
      end else if (rd_adv && !wr_en) begin
        cnt_d = cnt_q - 1'b1;
      end
      if (ovf_evt) begin
        ovf_d = ovf_sat_inc(ovf_q);
      end
    end
  end

  // Control state: pointers, occupancy and overflow counter, async cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Packet storage: written on accepted pushes, never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out = mem_q[rd_ptr_q];
  assign pndng    = !is_empty;
  assign full     = is_full;
  assign count    = cnt_q;
  assign ovf_cnt  = ovf_q;

endmodule

// File: rtl/multi_term_fifo.sv
// Bank of TERMS independent terminal FIFOs sharing only clock and reset.
// Packet and status buses are flat vectors sliced per terminal.
module multi_term_fifo
  import fifo_bank_pkg::*;
#(
  parameter int PCKG_SZ   = 40,
  parameter int DEEP_FIFO = 8,
  parameter int TERMS     = 4,
  parameter int OVF_MODE  = OVF_DROP
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [TERMS-1:0]                      push,
  input  logic [TERMS*PCKG_SZ-1:0]              data_in,
  input  logic [TERMS-1:0]                      pop,
  input  logic [TERMS-1:0]                      flush,
  output logic [TERMS*PCKG_SZ-1:0]              data_out,
  output logic [TERMS-1:0]                      pndng,
  output logic [TERMS-1:0]                      full,
  output logic [TERMS*($clog2(DEEP_FIFO)+1)-1:0] count,
  output logic [TERMS*OVF_CNT_W-1:0]            ovf_cnt
);

  localparam int CW = $clog2(DEEP_FIFO) + 1;

  for (genvar g = 0; g < TERMS; g++) begin : g_term
    term_fifo #(
      .PCKG_SZ   (PCKG_SZ),
      .DEEP_FIFO (DEEP_FIFO),
      .OVF_MODE  (OVF_MODE)
    ) u_term (
      .clk      (clk),
      .reset    (reset),
      .push     (push[g]),
      .data_in  (data_in[g*PCKG_SZ +: PCKG_SZ]),
      .pop      (pop[g]),
      .flush    (flush[g]),
      .data_out (data_out[g*PCKG_SZ +: PCKG_SZ]),
      .pndng    (pndng[g]),
      .full     (full[g]),
      .count    (count[g*CW +: CW]),
      .ovf_cnt  (ovf_cnt[g*OVF_CNT_W +: OVF_CNT_W])
    );
  end

endmodule
